// File: rtl/spi_reg_bridge.sv
// Executes one register-bus access per handshake request and returns a one-cycle ack.
// Optional bus timeout is compiled in with `define SPI_REG_BRIDGE_TIMEOUT_EN.
module spi_reg_bridge #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          req_it,
  output logic          ack_it,
  input  logic          cmd_rw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          ovr,
  input  logic          ovr_clr,
  output logic          bus_sel,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ready,
  input  logic          bus_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e        state_q, state_d;
  logic          bus_sel_q, bus_sel_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          ovr_q, ovr_d;

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_sel_d   = bus_sel_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_it) begin
          bus_we_d    = ~cmd_rw;
          bus_addr_d  = cmd_addr;
          bus_wdata_d = cmd_wdata;
          bus_sel_d   = 1'b1;
          state_d     = StAccess;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      StAccess: begin
        if (bus_ready) begin
          rsp_err_d = bus_err;
          if (!bus_we_q) rsp_rdata_d = bus_rdata;
          bus_sel_d = 1'b0;
          state_d   = StResp;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          // Abort: reads return all-ones so the SPI master sees an obvious bad value.
          rsp_err_d = 1'b1;
          if (!bus_we_q) rsp_rdata_d = {DW{1'b1}};
          bus_sel_d = 1'b0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A request while busy is dropped; setting the flag wins over a same-cycle clear.
  always_comb begin
    ovr_d = ovr_q;
    if (req_it && (state_q != StIdle)) ovr_d = 1'b1;
    else if (ovr_clr)                  ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= StIdle;
      bus_sel_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_sel_q   <= bus_sel_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ovr_q       <= ovr_d;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign ack_it    = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign bus_sel   = bus_sel_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge; timeout steps run only with SPI_REG_BRIDGE_TIMEOUT_EN.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_it, ack_it, cmd_rw;
  logic [7:0]  cmd_addr, bus_addr;
  logic [15:0] cmd_wdata, rsp_rdata, bus_wdata, bus_rdata;
  logic        rsp_err, busy, ovr, ovr_clr;
  logic        bus_sel, bus_we, bus_ready, bus_err;

  int errors = 0;
  int checks = 0;

  spi_reg_bridge #(.AW(8), .DW(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_it    (req_it),
    .ack_it    (ack_it),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [7:0] addr, input logic [15:0] wdata);
    req_it    = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    step();
    req_it    = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; req_it = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    ovr_clr = 1'b0; bus_rdata = '0; bus_ready = 1'b0; bus_err = 1'b0;
    #12;
    check("rst_outputs", {ack_it, busy, ovr, bus_sel, bus_we, rsp_err}, 32'h0);
    check("rst_data", {bus_addr, bus_wdata}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    rstb = 1'b1;
    step();

    // 1: zero-wait write
    bus_ready = 1'b1;
    issue(1'b0, 8'h12, 16'hBEEF);
    check("wr_sel", {bus_sel, bus_we, busy, ack_it}, 32'b1110);
    check("wr_addr", bus_addr, 32'h12);
    check("wr_wdata", bus_wdata, 32'hBEEF);
    step();
    check("wr_ack", {ack_it, bus_sel, rsp_err}, 32'b100);
    step();
    check("wr_done", {ack_it, busy}, 32'b00);
    check("wr_hold", {bus_we, bus_addr, bus_wdata}, {8'h0, 1'b1, 8'h12, 16'hBEEF});

    // 2: read with three wait states
    bus_ready = 1'b0;
    issue(1'b1, 8'h05, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_sel", {bus_sel, bus_we, ack_it}, 32'b100);
      step();
    end
    check("rd_4th_sel", {bus_sel, bus_addr}, {23'h0, 1'b1, 8'h05});
    bus_ready = 1'b1;
    bus_rdata = 16'h1234;
    step();
    bus_ready = 1'b0;
    check("rd_ack", {ack_it, bus_sel}, 32'b10);
    check("rd_rdata", rsp_rdata, 32'h1234);
    step();

    // 3: bus error then clean write
    bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 16'hA5A5;
    issue(1'b1, 8'h33, 16'h0000);
    step();
    bus_err = 1'b0;
    check("err_ack", {ack_it, rsp_err}, 32'b11);
    check("err_rdata", rsp_rdata, 32'hA5A5);
    step();
    issue(1'b0, 8'h34, 16'h5555);
    step();
    check("err_clear", {ack_it, rsp_err}, 32'b10);
    check("wr_keeps_rdata", rsp_rdata, 32'hA5A5);
    step();

    // 4: overrun
    bus_ready = 1'b0;
    issue(1'b0, 8'h40, 16'h1111);
    req_it = 1'b1; cmd_addr = 8'h41; cmd_wdata = 16'h2222;
    step();
    req_it = 1'b0;
    check("ovr_set", ovr, 32'h1);
    check("ovr_no_capture", {bus_addr, bus_wdata}, {8'h0, 8'h40, 16'h1111});
    req_it = 1'b1; ovr_clr = 1'b1;
    step();
    req_it = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", ovr, 32'h1);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    check("ovr_single_ack", {ack_it, bus_addr}, {23'h0, 1'b1, 8'h40});
    step();
    check("ovr_idle", {ack_it, busy, bus_sel}, 32'b000);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_cleared", ovr, 32'h0);

    // 5: reset mid-access
    issue(1'b1, 8'h07, 16'h0000);
    check("rst_mid_sel", {bus_sel, busy}, 32'b11);
    rstb = 1'b0;
    #1;
    check("rst_mid_outs", {bus_sel, busy, ack_it, rsp_err}, 32'b0000);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    step();
    step();
    rstb = 1'b1;
    step();
    check("rst_no_ack", {ack_it, busy}, 32'b00);
    bus_ready = 1'b1; bus_rdata = 16'h0F0F;
    issue(1'b1, 8'h08, 16'h0000);
    check("post_rst_sel", {bus_sel, bus_addr}, {23'h0, 1'b1, 8'h08});
    step();
    bus_ready = 1'b0;
    check("post_rst_ack", {ack_it, rsp_err}, 32'b10);
    check("post_rst_rdata", rsp_rdata, 32'h0F0F);
    step();

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
    // 6: timeout abort, then completion on the last allowed cycle
    issue(1'b1, 8'h09, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("to_sel", {bus_sel, ack_it}, 32'b10);
      step();
    end
    check("to_ack", {ack_it, bus_sel, rsp_err}, 32'b101);
    check("to_rdata", rsp_rdata, 32'hFFFF);
    step();
    issue(1'b1, 8'h0A, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("to_ok_sel", {bus_sel, ack_it}, 32'b10);
      if (i == 3) begin
        bus_ready = 1'b1;
        bus_rdata = 16'h2222;
      end
      step();
    end
    bus_ready = 1'b0;
    check("to_ok_ack", {ack_it, rsp_err}, 32'b10);
    check("to_ok_rdata", rsp_rdata, 32'h2222);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
